mem_port_arbiter: RTL and testbench

Shares one single-port synchronous memory between the multicycle CPU's instruction-fetch port and its data port, or between two such ports in general.
- Each requester uses a req/ack handshake.
- The arbiter serialises accesses, drives the memory interface and counts a fixed read latency.
- It returns read data to the requester that won arbitration.
- It sits between the CPU and the unified SRAM model.

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between an
// instruction-fetch port and a data port. Each access is issued with a
// one-cycle m_en pulse, waits a fixed MEM_LATENCY, then pulses the winner's ack
// for one cycle with the captured read data.
//
// Build option: `define ARB_FIXED_PRIO_EN makes the data port win every tie.
// Left undefined, ties alternate round-robin against the last grant.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_we,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              m_en,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_we,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0]        LAT        = 4'(MEM_LATENCY);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic              r_last_d;   // 1: last grant went to the data port
    logic              r_win_d;    // winner of the access in flight
    logic              r_is_wr;    // access in flight is a data-port write
    logic              w_grant_d;
    logic              w_issue;
    logic              w_done;
    logic [ADDR_W-1:0] w_addr;

    // Winner selection; a lone request always wins, only ties use the policy.
`ifdef ARB_FIXED_PRIO_EN
    assign w_grant_d = d_req;
`else
    assign w_grant_d = d_req & (~i_req | ~r_last_d);
`endif

    assign w_issue = (r_state == IDLE) & (i_req | d_req);
    assign w_done  = (r_state == ACCESS) & (r_cnt == 4'd0);
    assign w_addr  = w_grant_d ? d_addr : i_addr;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state: IDLE -> ACCESS on any request, ACCESS -> RESP when the
    // latency count expires, RESP always returns to IDLE (no issue in RESP).
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_issue) w_next = ACCESS;
            ACCESS:  if (w_done)  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: issue, latency count, read capture and ack pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= 4'd0;
            r_last_d <= 1'b1;
            r_win_d  <= 1'b0;
            r_is_wr  <= 1'b0;
            m_en     <= 1'b0;
            m_addr   <= '0;
            m_we     <= 4'd0;
            m_wdata  <= 32'd0;
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
            i_rdata  <= 32'd0;
            d_rdata  <= 32'd0;
        end else begin
            // m_en/m_we and the acks are single-cycle pulses
            m_en  <= 1'b0;
            m_we  <= 4'd0;
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            if (w_issue) begin
                m_en     <= 1'b1;
                m_addr   <= w_addr & ALIGN_MASK;
                m_we     <= w_grant_d ? d_we : 4'd0;
                m_wdata  <= w_grant_d ? d_wdata : 32'd0;
                r_cnt    <= LAT;
                r_last_d <= w_grant_d;
                r_win_d  <= w_grant_d;
                r_is_wr  <= w_grant_d & (|d_we);
            end
            if (r_state == ACCESS) begin
                if (r_cnt == 4'd0) begin
                    if (r_win_d) begin
                        d_ack <= 1'b1;
                        // a store completes without disturbing the last load
                        if (!r_is_wr) d_rdata <= m_rdata;
                    end else begin
                        i_ack   <= 1'b1;
                        i_rdata <= m_rdata;
                    end
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 1 and 4), each with a
// small SRAM model whose read data is valid only in the exact latency cycle.
// A transaction-level model predicts grant order, timing and data.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]       i_req, i_ack, d_req, d_ack, m_en;
    logic [1:0][31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata;
    logic [1:0][3:0]  d_we, m_we;

    // reference state owned by the stimulus process
    logic [31:0] refm [2][64];
    bit          last_d [2];
    logic [31:0] e_ir [2];
    logic [31:0] e_dr [2];
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h1234_5678;
        if (i == 8) return 32'hCAFE_0001;
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] we);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = we[b] ? n[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [31:0] mrd = 32'hBAD0_0000;
        logic [31:0] sram [64];
        logic [31:0] pend;
        int          cd;
        bit          act = 0;
        bit          loaded = 0;

        mem_port_arbiter #(.MEM_LATENCY(g == 0 ? 1 : 4), .ADDR_W(32)) u_dut (
            .clk(clk), .rst(rst),
            .i_req(i_req[g]), .i_addr(i_addr[g]), .i_ack(i_ack[g]), .i_rdata(i_rdata[g]),
            .d_req(d_req[g]), .d_addr(d_addr[g]), .d_we(d_we[g]), .d_wdata(d_wdata[g]),
            .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
            .m_en(m_en[g]), .m_addr(m_addr[g]), .m_we(m_we[g]), .m_wdata(m_wdata[g]),
            .m_rdata(mrd)
        );

        // SRAM: read data appears only in the cycle MEM_LATENCY after m_en
        always @(posedge clk) begin
            if (!loaded) begin
                for (int i = 0; i < 64; i++) sram[i] = init_word(i);
                loaded = 1;
            end
            if (m_en[g]) begin
                pend = sram[m_addr[g][7:2]];
                sram[m_addr[g][7:2]] = merge(sram[m_addr[g][7:2]], m_wdata[g], m_we[g]);
                cd  = lat(g) - 1;
                act = 1;
                mrd <= (cd == 0) ? pend : $urandom;
            end else if (act) begin
                if (cd == 0) begin
                    act = 0;
                    mrd <= $urandom;
                end else begin
                    cd = cd - 1;
                    mrd <= (cd == 0) ? pend : $urandom;
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        i_req = '0; d_req = '0; i_addr = '0; d_addr = '0; d_we = '0; d_wdata = '0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (m_en[k] !== 0 || m_addr[k] !== 0 || m_we[k] !== 0 || m_wdata[k] !== 0 ||
                i_ack[k] !== 0 || d_ack[k] !== 0 || i_rdata[k] !== 0 || d_rdata[k] !== 0) begin
                n_fail++;
                $display("FAIL reset dut%0d: en=%b addr=%h we=%h wd=%h iack=%b dack=%b ird=%h drd=%h, want all 0",
                         k, m_en[k], m_addr[k], m_we[k], m_wdata[k], i_ack[k], d_ack[k], i_rdata[k], d_rdata[k]);
            end
            last_d[k] = 1; e_ir[k] = 0; e_dr[k] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_chk++;
            if (m_en[k] !== 0 || i_ack[k] !== 0 || d_ack[k] !== 0) begin
                n_fail++;
                $display("FAIL idle_after_reset dut%0d: en=%b iack=%b dack=%b, want 0", k, m_en[k], i_ack[k], d_ack[k]);
            end
        end
    endtask

    // One arbitration round: raise the chosen requests together, drop each
    // the cycle after its ack, check every issue and ack against the model.
    task automatic run_round(input int k, input bit ri, input bit rd, input logic [31:0] ia,
                             input logic [31:0] da, input logic [3:0] dwe, input logic [31:0] dwd);
        int L, n, j, q, jj, qq;
        bit port [2];
        logic [31:0] ea [2], ewd [2], erd [2], a;
        logic [3:0] ewe [2];
        bit drop_i, drop_d, got_d;
        L = lat(k); n = 0; j = 0; q = 0;
        if (ri && rd) begin
`ifdef ARB_FIXED_PRIO_EN
            port[0] = 1;
`else
            port[0] = !last_d[k];
`endif
            port[1] = !port[0];
            n = 2;
        end else begin
            port[0] = rd;
            n = 1;
        end
        for (int x = 0; x < n; x++) begin
            a = port[x] ? da : ia;
            ea[x] = {a[31:2], 2'b00};
            if (port[x]) begin
                ewe[x] = dwe; ewd[x] = dwd;
                if (dwe == 0) e_dr[k] = refm[k][a[7:2]];
                else refm[k][a[7:2]] = merge(refm[k][a[7:2]], dwd, dwe);
                erd[x] = e_dr[k];
            end else begin
                ewe[x] = 0; ewd[x] = 0;
                e_ir[k] = refm[k][a[7:2]];
                erd[x] = e_ir[k];
            end
            last_d[k] = port[x];
        end
        @(posedge clk); #1;
        i_req[k] = ri; i_addr[k] = ia; d_req[k] = rd; d_addr[k] = da; d_we[k] = dwe; d_wdata[k] = dwd;
        for (int c = 0; c < 3 + n * (3 + L); c++) begin
            @(negedge clk);
            drop_i = 0; drop_d = 0;
            if (m_en[k]) begin
                jj = (j < n) ? j : 0;
                n_chk++;
                if (j >= n || c != 1 + j * (3 + L) || m_addr[k] !== ea[jj] || m_we[k] !== ewe[jj] || m_wdata[k] !== ewd[jj]) begin
                    n_fail++;
                    $display("FAIL issue dut%0d: got cyc=%0d addr=%h we=%h wd=%h; want grant#%0d cyc=%0d addr=%h we=%h wd=%h",
                             k, c, m_addr[k], m_we[k], m_wdata[k], j, 1 + j * (3 + L), ea[jj], ewe[jj], ewd[jj]);
                end
                j++;
            end
            if (i_ack[k] || d_ack[k]) begin
                qq = (q < n) ? q : 0;
                got_d = d_ack[k];
                n_chk++;
                if (q >= n || (i_ack[k] && d_ack[k]) || c != 2 + L + q * (3 + L) || got_d != port[qq] ||
                    (got_d ? d_rdata[k] : i_rdata[k]) !== erd[qq]) begin
                    n_fail++;
                    $display("FAIL ack dut%0d: got cyc=%0d iack=%b dack=%b rdata=%h; want ack#%0d cyc=%0d port=%s rdata=%h",
                             k, c, i_ack[k], d_ack[k], got_d ? d_rdata[k] : i_rdata[k], q, 2 + L + q * (3 + L),
                             port[qq] ? "D" : "I", erd[qq]);
                end
                drop_i = i_ack[k]; drop_d = d_ack[k];
                q++;
            end
            @(posedge clk); #1;
            if (drop_i) i_req[k] = 0;
            if (drop_d) d_req[k] = 0;
        end
        n_chk++;
        if (j != n || q != n) begin
            n_fail++;
            $display("FAIL round_count dut%0d: got issues=%0d acks=%0d, want %0d each", k, j, q, n);
        end
        i_req[k] = 0; d_req[k] = 0;
    endtask

    task automatic test_fetch();
        run_round(0, 1, 0, 32'h0000_0006, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic test_write();
        run_round(0, 0, 1, 32'h0, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
    endtask

    task automatic test_alternation();
        for (int r = 0; r < 2; r++)
            run_round(0, 1, 1, 32'h0000_0040 + 32'(r * 4), 32'h0000_0080 + 32'(r * 4), 4'h0, 32'h0);
    endtask

    task automatic test_latency4();
        run_round(1, 0, 1, 32'h0, 32'h0000_0020, 4'h0, 32'h0);
    endtask

    task automatic test_reset_mid();
        bit seen;
        @(posedge clk); #1;
        d_req[0] = 1; d_addr[0] = 32'h0000_0030; d_we[0] = 4'hF; d_wdata[0] = 32'h0BAD_F00D;
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (m_en[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_issue: got m_en=%b, want 1", m_en[0]);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if (m_en[0] !== 0 || m_addr[0] !== 0 || m_we[0] !== 0 || m_wdata[0] !== 0 ||
            i_ack[0] !== 0 || d_ack[0] !== 0 || i_rdata[0] !== 0 || d_rdata[0] !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: en=%b addr=%h we=%h wd=%h iack=%b dack=%b ird=%h drd=%h, want all 0",
                     m_en[0], m_addr[0], m_we[0], m_wdata[0], i_ack[0], d_ack[0], i_rdata[0], d_rdata[0]);
        end
        for (int k = 0; k < 2; k++) begin
            last_d[k] = 1; e_ir[k] = 0; e_dr[k] = 0;
        end
        @(posedge clk); #1 d_req[0] = 0;
        @(posedge clk); #1 rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (d_ack[0] || i_ack[0] || m_en[0]) seen = 1;
        end
        n_chk++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_mid_no_ack: got activity after abandoned access, want none");
        end
        run_round(0, 1, 1, 32'h0000_0050, 32'h0000_0054, 4'h0, 32'h0);
    endtask

    task automatic test_hold_req();
        int ne, na;
        logic [31:0] exp;
        exp = refm[0][17];
        e_ir[0] = exp; last_d[0] = 0;
        ne = 0; na = 0;
        @(posedge clk); #1;
        i_req[0] = 1; i_addr[0] = 32'h0000_0044;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (m_en[0]) begin
                n_chk++;
                if (c != (ne == 0 ? 1 : 5) || m_addr[0] !== 32'h0000_0044 || m_we[0] !== 0) begin
                    n_fail++;
                    $display("FAIL hold_issue: got cyc=%0d addr=%h we=%h, want cyc=%0d addr=00000044 we=0",
                             c, m_addr[0], m_we[0], ne == 0 ? 1 : 5);
                end
                ne++;
            end
            if (i_ack[0] || d_ack[0]) begin
                n_chk++;
                if (d_ack[0] || c != (na == 0 ? 3 : 7) || i_rdata[0] !== exp) begin
                    n_fail++;
                    $display("FAIL hold_ack: got cyc=%0d dack=%b ird=%h, want cyc=%0d iack rdata=%h",
                             c, d_ack[0], i_rdata[0], na == 0 ? 3 : 7, exp);
                end
                na++;
            end
            @(posedge clk); #1;
            if (c == 5) i_req[0] = 0;
        end
        n_chk++;
        if (ne != 2 || na != 2) begin
            n_fail++;
            $display("FAIL hold_count: got issues=%0d acks=%0d, want 2 each", ne, na);
        end
    endtask

    task automatic test_random();
        int k, pat;
        logic [3:0] we;
        for (int r = 0; r < 24; r++) begin
            k   = $urandom_range(0, 1);
            pat = $urandom_range(1, 3);
            we  = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            run_round(k, pat[0], pat[1], 32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), we, $urandom);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 64; i++) refm[k][i] = init_word(i);
        test_reset();
        test_fetch();
        test_write();
        test_alternation();
        test_latency4();
        test_reset_mid();
        test_hold_req();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
